l1_mem_arbiter: RTL

Arbitrates the instruction-cache and data-cache miss ports onto the single shared memory-side port (cacheline adapter / L2) in the cache hierarchy. It accepts line-granular read requests from the I-cache and read/writeback requests from the D-cache, and grants one at a time. It holds the granted request on the memory port until the memory response, then routes the response back to the owner. All memory-port outputs are registered, so the arbiter adds exactly one cycle of request latency.

---
 rtl/l1_arb_pkg.sv | 23 ++
 rtl/l1_arb_chk.sv | 14 +
 rtl/l1_arb_pick.sv | 39 +++
 rtl/l1_mem_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/l1_arb_pkg.sv
// l1_arb_pkg: shared types and widths for the L1 miss-port arbiter.
// The round-robin tie-break is enabled by defining L1_ARB_RR_EN.
package l1_arb_pkg;

    // Widths shared with the I-cache and D-cache miss ports.
    localparam int S_ADDR = 32;
    localparam int S_LINE = 256;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    // Requester identity, used for the grant and the last-grant history.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } arb_req_t;

endpackage : l1_arb_pkg

// File: rtl/l1_arb_chk.sv
// l1_arb_chk: simulation-only protocol checks for the arbiter inputs.
// A D-cache read and writeback must never be requested together.
module l1_arb_chk (
    input logic clk,
    input logic rst,
    input logic d_read,
    input logic d_write
);

    a_d_read_write_exclusive: assert property (
        @(posedge clk) disable iff (rst) !(d_read && d_write)
    );

endmodule : l1_arb_chk

// File: rtl/l1_arb_pick.sv
// l1_arb_pick: combinational winner selection between the I-cache and
// D-cache miss requests.
// With L1_ARB_RR_EN defined, ties alternate using last_grant; otherwise
// the D-cache always wins a tie.
module l1_arb_pick
    import l1_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
`ifdef L1_ARB_RR_EN
    input  arb_req_t last_grant,
`endif
    output logic     o_valid,
    output arb_req_t o_grant
);

    // Pick the winner; a lone requester always wins.
    always_comb begin
        o_valid = i_req | d_req;
        o_grant = REQ_I;
        if (d_req && !i_req) begin
            o_grant = REQ_D;
        end else if (d_req && i_req) begin
`ifdef L1_ARB_RR_EN
            // The requester that was not served last time wins the tie.
            if (last_grant == REQ_I) begin
                o_grant = REQ_D;
            end else begin
                o_grant = REQ_I;
            end
`else
            o_grant = REQ_D;
`endif
        end else begin
            o_grant = REQ_I;
        end
    end

endmodule : l1_arb_pick

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: arbitrates the I-cache and D-cache miss ports onto the
// single memory-side port. Memory-port outputs are registered; responses
// are routed back to the owner combinationally in the m_resp cycle.
// Optional feature: L1_ARB_RR_EN selects round-robin tie-breaking instead
// of fixed D-over-I priority.
module l1_mem_arbiter
    import l1_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    // I-cache miss port
    input  logic              i_read,
    input  logic [S_ADDR-1:0] i_addr,
    output logic [S_LINE-1:0] i_rdata,
    output logic              i_resp,
    // D-cache miss port
    input  logic              d_read,
    input  logic              d_write,
    input  logic [S_ADDR-1:0] d_addr,
    input  logic [S_LINE-1:0] d_wdata,
    output logic [S_LINE-1:0] d_rdata,
    output logic              d_resp,
    // memory-side port
    output logic              m_read,
    output logic              m_write,
    output logic [S_ADDR-1:0] m_addr,
    output logic [S_LINE-1:0] m_wdata,
    input  logic [S_LINE-1:0] m_rdata,
    input  logic              m_resp
);

    arb_state_t        r_state;
    logic              r_m_read;
    logic              r_m_write;
    logic [S_ADDR-1:0] r_m_addr;
    logic [S_LINE-1:0] r_m_wdata;

    logic              w_d_req;
    logic              w_grant_valid;
    arb_req_t          w_grant;

`ifdef L1_ARB_RR_EN
    arb_req_t          r_last_grant;
`endif

    assign w_d_req = d_read | d_write;

    l1_arb_pick u_pick (
        .i_req      (i_read),
        .d_req      (w_d_req),
`ifdef L1_ARB_RR_EN
        .last_grant (r_last_grant),
`endif
        .o_valid    (w_grant_valid),
        .o_grant    (w_grant)
    );

    l1_arb_chk u_chk (
        .clk     (clk),
        .rst     (rst),
        .d_read  (d_read),
        .d_write (d_write)
    );

    // FSM and memory-port output registers: grant in IDLE, hold until m_resp,
    // then one DONE cycle so the served cache can drop its request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= {S_ADDR{1'b0}};
            r_m_wdata <= {S_LINE{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        if (w_grant == REQ_D) begin
                            r_state   <= SERVE_D;
                            r_m_addr  <= d_addr;
                            r_m_wdata <= d_wdata;
                            // An illegal read+write collapses to the writeback.
                            r_m_write <= d_write;
                            r_m_read  <= d_read & ~d_write;
                        end else begin
                            r_state   <= SERVE_I;
                            r_m_addr  <= i_addr;
                            r_m_wdata <= {S_LINE{1'b0}};
                            r_m_write <= 1'b0;
                            r_m_read  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (m_resp) begin
                        r_state   <= DONE;
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_m_read  <= 1'b0;
                    r_m_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef L1_ARB_RR_EN
    // Grant history for the tie-break; starts at I so D wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_I;
        end else if (r_state == IDLE && w_grant_valid) begin
            r_last_grant <= w_grant;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end
`endif

    // Route the memory response to the current owner only; m_resp outside a
    // SERVE state is dropped.
    always_comb begin
        i_resp  = 1'b0;
        d_resp  = 1'b0;
        i_rdata = {S_LINE{1'b0}};
        d_rdata = {S_LINE{1'b0}};
        if (m_resp && r_state == SERVE_I) begin
            i_resp  = 1'b1;
            i_rdata = m_rdata;
        end else if (m_resp && r_state == SERVE_D) begin
            d_resp  = 1'b1;
            d_rdata = m_rdata;
        end else begin
            i_resp = 1'b0;
            d_resp = 1'b0;
        end
    end

    assign m_read  = r_m_read;
    assign m_write = r_m_write;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

endmodule : l1_mem_arbiter
